// File: rtl/daub6_pkg.sv
// Shared definitions for the daub6 filter chain: decimator FSM states and the
// default sample width.
package daub6_pkg;

    localparam int DAUB6_DATA_WIDTH = 16;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } daub6_state_e;

endpackage

// File: rtl/daub6_sync_fifo.sv
// Single-clock FIFO with exact occupancy count; head word is driven from the
// storage array, so there is no combinational path from write data to read data.
module daub6_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/daub6_decim_buf.sv
// 2:1 decimator with warm-up skip and output FIFO for the daub6 filter output.
// Optional drop counter output enabled by DAUB6_DECIM_DROPCNT_EN.
module daub6_decim_buf
    import daub6_pkg::*;
#(
    parameter int DATA_WIDTH = DAUB6_DATA_WIDTH,
    parameter int DEPTH      = 8,
    parameter int SKIP       = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in,
    input  logic                         in_valid,
    input  logic                         phase_sync,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
`ifdef DAUB6_DECIM_DROPCNT_EN
    output logic [15:0]                  drop_cnt,
`endif
    output daub6_state_e                 state_dbg
);

    // Handshake: a sample leaves the FIFO on a rising edge where out_valid and
    // out_ready are both high; out and out_valid are stable otherwise.

    localparam int SKW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    daub6_state_e           state;
    logic [SKW-1:0]         skip_cnt;
    logic                   phase;
    logic                   keep;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_WIDTH-1:0]  fifo_rdata;

    assign keep      = (state == RUN) & in_valid & (phase_sync | ~phase);
    assign drop      = keep & fifo_full & ~(out_valid & out_ready);
    assign out_valid = ~fifo_empty;
    assign out       = fifo_rdata;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WARMUP;
            skip_cnt <= SKW'(SKIP);
            phase    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                WARMUP: begin
                    // phase_sync has no effect until the filter transient is gone.
                    if (skip_cnt == '0) begin
                        state <= RUN;
                    end else if (in_valid) begin
                        skip_cnt <= skip_cnt - SKW'(1);
                        if (skip_cnt == SKW'(1)) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        phase <= phase_sync ? 1'b1 : ~phase;
                    end
                end
                default: state <= WARMUP;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef DAUB6_DECIM_DROPCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    daub6_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .wdata (in),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

endmodule

// File: tb/tb_daub6_decim_buf.sv
// Directed bench for daub6_decim_buf (DATA_WIDTH=16, DEPTH=8, SKIP=5).
module tb_daub6_decim_buf;
    import daub6_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] in_s;
    logic               in_valid;
    logic               phase_sync;
    logic signed [15:0] out;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         level;
    logic               overflow;
    daub6_state_e       state_dbg;
`ifdef DAUB6_DECIM_DROPCNT_EN
    logic [15:0]        drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic signed [15:0] din;
        logic               exp_valid;
        logic signed [15:0] exp_out;
        logic [3:0]         exp_level;
    } vec_t;
    vec_t tbl[20];

    daub6_decim_buf #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .SKIP       (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in_s),
        .in_valid   (in_valid),
        .phase_sync (phase_sync),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .overflow   (overflow),
`ifdef DAUB6_DECIM_DROPCNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic signed [15:0] d, input logic v, input logic s, input logic r);
        in_s       = d;
        in_valid   = v;
        phase_sync = s;
        out_ready  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(16'sd0, 1'b0, 1'b0, 1'b0);
        step(16'sd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic warmup(input logic s3);
        for (int i = 1; i <= 5; i++) begin
            step(16'(i), 1'b1, (i == 3) ? s3 : 1'b0, 1'b0);
        end
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
            check16({name, "_data"}, out, exp_q.pop_front());
            step(16'sd0, 1'b0, 1'b0, 1'b1);
        end
        check({name, "_empty_level"}, {28'b0, level}, 32'd0);
        check({name, "_empty_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int first_cycle;
        int kept;

        rst = 1'b1; in_s = '0; in_valid = 1'b0; phase_sync = 1'b0; out_ready = 1'b0;

        // Free-running stream 1..20 with consumer always ready.
        for (int k = 1; k <= 20; k++) begin
            tbl[k-1].din       = 16'(k);
            tbl[k-1].exp_valid = (k >= 6) && (k % 2 == 0);
            tbl[k-1].exp_out   = tbl[k-1].exp_valid ? 16'(k) : 16'sd0;
            tbl[k-1].exp_level = tbl[k-1].exp_valid ? 4'd1 : 4'd0;
        end

        do_reset();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_level", {28'b0, level}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check16("rst_out", out, 16'h0000);
        check("rst_state", {31'b0, state_dbg}, {31'b0, WARMUP});
`ifdef DAUB6_DECIM_DROPCNT_EN
        check16("rst_drop_cnt", drop_cnt, 16'd0);
`endif

        first_cycle = 0;
        for (int k = 0; k < 20; k++) begin
            step(tbl[k].din, 1'b1, 1'b0, 1'b1);
            check("tbl_valid", {31'b0, out_valid}, {31'b0, tbl[k].exp_valid});
            check16("tbl_out", out, tbl[k].exp_out);
            check("tbl_level", {28'b0, level}, {28'b0, tbl[k].exp_level});
            // Cycle k+2 is the cycle that follows edge k+1 after rst fell.
            if (out_valid && first_cycle == 0) first_cycle = k + 2;
        end
        check("first_valid_cycle", first_cycle, 32'd7);

        // Consumer stalled for 30 valid cycles: FIFO fills, 7 kept samples drop.
        do_reset();
        warmup(1'b0);
        check("warm_state_run", {31'b0, state_dbg}, {31'b0, RUN});
        check("warm_level", {28'b0, level}, 32'd0);
        kept = 0;
        for (int i = 0; i < 30; i++) begin
            step(16'(101 + i), 1'b1, 1'b0, 1'b0);
            if (i % 2 == 0) begin
                if (kept < 8) exp_q.push_back(16'(101 + i));
                kept++;
            end
        end
        check("ovf_level", {28'b0, level}, 32'd8);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
`ifdef DAUB6_DECIM_DROPCNT_EN
        check16("ovf_drop_cnt", drop_cnt, 16'd7);
`endif
        check16("ovf_hold_head", out, 16'd101);
        drain("ovf_drain");
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        warmup(1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(16'(i), 1'b1, 1'b0, 1'b0);
            if (i % 2 == 1) exp_q.push_back(16'(i));
        end
        check("full_level", {28'b0, level}, 32'd8);
        check("full_overflow", {31'b0, overflow}, 32'd0);
        step(16'sd50, 1'b1, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(16'd50);
        check("pp_level", {28'b0, level}, 32'd8);
        check("pp_overflow", {31'b0, overflow}, 32'd0);
        drain("pp_drain");

        // phase_sync ignored in warm-up, then forces a keep on an odd-phase sample.
        do_reset();
        warmup(1'b1);
        check("sync_warm_level", {28'b0, level}, 32'd0);
        step(16'sd10, 1'b1, 1'b0, 1'b0);
        step(16'sd100, 1'b1, 1'b1, 1'b0);
        step(16'sd11, 1'b1, 1'b0, 1'b0);
        step(16'sd77, 1'b0, 1'b0, 1'b0);
        step(16'sd12, 1'b1, 1'b0, 1'b0);
        check("sync_level", {28'b0, level}, 32'd3);
        exp_q.push_back(16'd10);
        exp_q.push_back(16'd100);
        exp_q.push_back(16'd12);
        drain("sync_drain");

        // Mid-stream reset with level 5 and overflow set.
        do_reset();
        warmup(1'b0);
        for (int i = 0; i < 20; i++) step(16'(200 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(16'sd0, 1'b0, 1'b0, 1'b1);
        check("mid_pre_level", {28'b0, level}, 32'd5);
        check("mid_pre_overflow", {31'b0, overflow}, 32'd1);
        rst = 1'b1;
        step(16'sd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_level", {28'b0, level}, 32'd0);
        check("mid_rst_overflow", {31'b0, overflow}, 32'd0);
`ifdef DAUB6_DECIM_DROPCNT_EN
        check16("mid_rst_drop_cnt", drop_cnt, 16'd0);
`endif
        for (int i = 0; i < 5; i++) step(16'(300 + i), 1'b1, 1'b0, 1'b1);
        check("mid_rewarm_level", {28'b0, level}, 32'd0);
        check("mid_rewarm_valid", {31'b0, out_valid}, 32'd0);
        step(16'sd305, 1'b1, 1'b0, 1'b0);
        check("mid_first_valid", {31'b0, out_valid}, 32'd1);
        check16("mid_first_out", out, 16'd305);

        // Extreme values pass through bit-exactly.
        do_reset();
        warmup(1'b0);
        step(-16'sd32768, 1'b1, 1'b0, 1'b0);
        step(16'sd0, 1'b1, 1'b0, 1'b0);
        step(16'sd32767, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h7FFF);
        drain("extreme_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
